// File: rtl/logic_unit_pkg.sv
// Shared encodings for the registered bitwise logic unit:
// operation selects and burst-accumulate FSM states.
package logic_unit_pkg;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_NAND = 3'b011;
   localparam logic [2:0] OP_NOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_ANDN = 3'b110;
   localparam logic [2:0] OP_PASS = 3'b111;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

endpackage

// File: rtl/logic_unit_pipe_op_core.sv
// Combinational WIDTH-bit bitwise function y = f(op, a, b); shared by the
// single-op path and the accumulate fold.
module logic_op_core
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = a;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XNOR: y = ~(a ^ b);
         OP_ANDN: y = a & ~b;
         OP_PASS: y = a;
      endcase
   end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshake, 1-cycle latency and
// an accumulate mode that folds a burst of in1 words into a single result.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter  int WIDTH     = 32,
   parameter  int MAX_BURST = 16,
   localparam int BW        = $clog2(MAX_BURST + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic             in_acc,
   input  logic             in_last,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_zero,
   output logic             out_ones,
   output logic [BW-1:0]    out_beats,
   output logic             out_trunc
);

   localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);
   localparam logic [BW-1:0] ONE_BEAT    = BW'(1);

   state_t           state_p1;
   logic [WIDTH-1:0] acc_p1;
   logic [2:0]       op_p1;
   logic [BW-1:0]    cnt_p1;

   logic             accept;
   logic             acc_first;
   logic             acc_cont;
   logic             burst_end;
   logic [2:0]       core_op;
   logic [WIDTH-1:0] core_a;
   logic [WIDTH-1:0] core_b;
   logic [WIDTH-1:0] core_y;
   logic [BW-1:0]    cnt_next;
   logic             vld_p0;
   logic [WIDTH-1:0] result_p0;
   logic [BW-1:0]    beats_p0;
   logic             trunc_p0;

   // Ready whenever the output slot is empty or being drained this cycle.
   assign in_ready = rst_n & (~out_valid | out_ready);

   // Stage p0: operand selection and the shared bitwise core
   always_comb begin
      accept    = in_valid & in_ready;
      acc_first = in_acc & (state_p1 == IDLE);
      acc_cont  = in_acc & (state_p1 == ACCUM);
      core_op   = acc_cont ? op_p1  : in_op;
      core_a    = acc_cont ? acc_p1 : in1;
      core_b    = acc_cont ? in1    : in2;
      cnt_next  = cnt_p1 + 1'b1;
      burst_end = in_last | (cnt_next == BURST_LIMIT);
      result_p0 = acc_first ? in1 : core_y;
      beats_p0  = acc_cont ? cnt_next : ONE_BEAT;
      trunc_p0  = acc_cont & ~in_last;
      vld_p0    = accept & (~in_acc | (acc_first & in_last) | (acc_cont & burst_end));
   end

   logic_op_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op (core_op),
      .a  (core_a),
      .b  (core_b),
      .y  (core_y)
   );

   // Burst FSM: single-op beats leave the accumulator untouched.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_p1 <= IDLE;
         acc_p1   <= '0;
         op_p1    <= OP_AND;
         cnt_p1   <= '0;
      end else if (accept && in_acc) begin
         case (state_p1)
            IDLE: begin
               if (!in_last) begin
                  acc_p1   <= in1;
                  op_p1    <= in_op;
                  cnt_p1   <= ONE_BEAT;
                  state_p1 <= ACCUM;
               end
            end
            ACCUM: begin
               if (burst_end) begin
                  acc_p1   <= '0;
                  cnt_p1   <= '0;
                  state_p1 <= IDLE;
               end else begin
                  acc_p1 <= core_y;
                  cnt_p1 <= cnt_next;
               end
            end
            default: state_p1 <= IDLE;
         endcase
      end
   end

   // Stage p1: output register; holds while the consumer stalls
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out       <= '0;
         out_zero  <= 1'b0;
         out_ones  <= 1'b0;
         out_beats <= '0;
         out_trunc <= 1'b0;
      end else if (vld_p0) begin
         out_valid <= 1'b1;
         out       <= result_p0;
         out_zero  <= ~|result_p0;
         out_ones  <= &result_p0;
         out_beats <= beats_p0;
         out_trunc <= trunc_p0;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: directed scenarios plus random traffic,
// expected results come from a burst-level reference model.
module tb_logic_unit_pipe;

   localparam int WIDTH     = 32;
   localparam int MAX_BURST = 4;
   localparam int BW        = $clog2(MAX_BURST + 1);

   typedef struct {
      logic [WIDTH-1:0] v;
      logic [BW-1:0]    beats;
      logic             trunc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic             in_acc;
   logic             in_last;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out;
   logic             out_zero;
   logic             out_ones;
   logic [BW-1:0]    out_beats;
   logic             out_trunc;

   int checks = 0;
   int errors = 0;

   exp_t             exp_q[$];
   logic [WIDTH-1:0] words[$];
   bit               in_burst = 0;
   logic [2:0]       burst_op = 3'd0;

   int cyc         = 0;
   int stall_until = 0;
   bit rnd_ready   = 0;

   logic_unit_pipe #(
      .WIDTH     (WIDTH),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_acc    (in_acc),
      .in_last   (in_last),
      .in1       (in1),
      .in2       (in2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_zero  (out_zero),
      .out_ones  (out_ones),
      .out_beats (out_beats),
      .out_trunc (out_trunc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (cyc < stall_until) out_ready = 1'b0;
      else if (rnd_ready)    out_ready = 1'($urandom_range(0, 1));
      else                   out_ready = 1'b1;
   end

   function automatic logic [WIDTH-1:0] f(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a & b);
         3'd4:    return ~(a | b);
         3'd5:    return ~(a ^ b);
         3'd6:    return a & ~b;
         default: return a;
      endcase
   endfunction

   // Reference model: bursts are collected as word lists and folded when they close.
   task automatic model(input logic acc, input logic last, input logic [2:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      if (!acc) begin
         exp_q.push_back('{v: f(op, a, b), beats: BW'(1), trunc: 1'b0});
      end else if (!in_burst) begin
         if (last) exp_q.push_back('{v: a, beats: BW'(1), trunc: 1'b0});
         else begin
            in_burst = 1;
            burst_op = op;
            words.delete();
            words.push_back(a);
         end
      end else begin
         words.push_back(a);
         if (last || words.size() == MAX_BURST) begin
            r = words[0];
            for (int i = 1; i < words.size(); i++) r = f(burst_op, r, words[i]);
            exp_q.push_back('{v: r, beats: BW'(words.size()), trunc: !last});
            in_burst = 0;
            words.delete();
         end
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat is taken.
   task automatic beat(input logic acc, input logic last, input logic [2:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      bit done = 0;
      in_valid = 1'b1;
      in_acc   = acc;
      in_last  = last;
      in_op    = op;
      in1      = a;
      in2      = b;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (in_ready) begin
            model(acc, last, op, a, b);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL beat_accept: in_ready stuck at %0b, required 1 within 200 cycles", in_ready);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || out_valid) begin
         errors++;
         $display("FAIL drain: %0d results still pending (out_valid=%0b), required 0",
                  exp_q.size(), out_valid);
      end
   endtask

   // Monitor: handshake, stability and reset checks at the falling edge.
   bit               rst_low_prev = 0;
   bit               stalled_prev = 0;
   logic [WIDTH+BW+3:0] snap_prev;

   always @(negedge clk) begin
      logic [WIDTH+BW+3:0] snap;
      exp_t e;
      snap = {out_valid, out, out_zero, out_ones, out_beats, out_trunc};
      checks++;
      if (in_ready !== (rst_n & (~out_valid | out_ready))) begin
         errors++;
         $display("FAIL in_ready: got %0b, required %0b", in_ready, rst_n & (~out_valid | out_ready));
      end
      if (!rst_n) begin
         if (rst_low_prev) begin
            checks++;
            if (snap !== '0) begin
               errors++;
               $display("FAIL reset_state: got valid=%0b out=%h z=%0b o=%0b beats=%0d trunc=%0b, required all 0",
                        out_valid, out, out_zero, out_ones, out_beats, out_trunc);
            end
         end
      end else begin
         if (stalled_prev) begin
            checks++;
            if (snap !== snap_prev) begin
               errors++;
               $display("FAIL stall_hold: got %h, required %h", snap, snap_prev);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: got out=%h beats=%0d, required no output", out, out_beats);
            end else begin
               e = exp_q.pop_front();
               if (out !== e.v || out_beats !== e.beats || out_trunc !== e.trunc ||
                   out_zero !== (e.v == '0) || out_ones !== (&e.v)) begin
                  errors++;
                  $display("FAIL result: got out=%h z=%0b o=%0b beats=%0d trunc=%0b, required out=%h z=%0b o=%0b beats=%0d trunc=%0b",
                           out, out_zero, out_ones, out_beats, out_trunc,
                           e.v, (e.v == '0), (&e.v), e.beats, e.trunc);
               end
            end
         end
      end
      rst_low_prev = !rst_n;
      stalled_prev = rst_n && out_valid && !out_ready;
      snap_prev    = snap;
   end

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_acc   = 1'b0;
      in_last  = 1'b0;
      in_op    = 3'd0;
      in1      = '0;
      in2      = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      beat(0, 0, 3'd0, 32'h0000A5A5, 32'h00005A5A);
      beat(0, 0, 3'd1, 32'h0000A5A5, 32'h00005A5A);
      beat(0, 0, 3'd3, 32'h00000000, 32'h00000000);
      beat(0, 0, 3'd6, 32'hFFFF0000, 32'hF0F0F0F0);
      beat(0, 0, 3'd2, 32'h12345678, 32'h0F0F0F0F);
      beat(0, 0, 3'd4, 32'h00000000, 32'h00000000);
      beat(0, 0, 3'd5, 32'hDEADBEEF, 32'hDEADBEEF);
      beat(0, 0, 3'd7, 32'hCAFEF00D, 32'h11111111);
      drain();

      stall_until = cyc + 5;
      beat(0, 0, 3'd1, 32'h00000011, 32'h00000100);
      beat(0, 0, 3'd2, 32'h000000FF, 32'h0000000F);
      drain();

      beat(1, 0, 3'd1, 32'h1, 32'h0);
      beat(1, 0, 3'd0, 32'h2, 32'h0);
      beat(1, 0, 3'd2, 32'h4, 32'h0);
      beat(1, 1, 3'd3, 32'h8, 32'h0);
      drain();

      for (int i = 0; i < 5; i++) beat(1, 0, 3'd2, 32'h11 << i, 32'h0);
      beat(1, 1, 3'd0, 32'hFFFFFFFF, 32'h0);
      beat(1, 1, 3'd0, 32'h0BADCAFE, 32'h0);
      drain();

      beat(1, 0, 3'd0, 32'hFF00FF00, 32'h0);
      beat(0, 0, 3'd1, 32'h00000003, 32'h0000000C);
      beat(1, 1, 3'd1, 32'h0F0F0F0F, 32'h0);
      drain();

      beat(1, 0, 3'd2, 32'hAAAA0000, 32'h0);
      beat(1, 0, 3'd2, 32'h0000AAAA, 32'h0);
      rst_n = 1'b0;
      in_burst = 0;
      words.delete();
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
      beat(0, 0, 3'd0, 32'h3, 32'h6);
      drain();

      rnd_ready = 1;
      for (int i = 0; i < 400; i++) begin
         logic [WIDTH-1:0] a, b;
         case ($urandom_range(0, 5))
            0:       a = '0;
            1:       a = '1;
            default: a = $urandom;
         endcase
         b = ($urandom_range(0, 4) == 0) ? a : $urandom;
         beat(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
              3'($urandom_range(0, 7)), a, b);
      end
      rnd_ready = 0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
